// File: rtl/stopwatch_bcd_pkg.sv
// Shared definitions for the mm:ss stopwatch: FSM encoding, BCD digit limits
// and the carry-chained BCD increment.
package stopwatch_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0]  UNIT_MAX   = 4'd9;
  localparam logic [3:0]  TENS_MAX   = 4'd5;
  localparam logic [15:0] DIGITS_MAX = {TENS_MAX, UNIT_MAX, TENS_MAX, UNIT_MAX};

  // One-second increment of mm:ss; carries ripple upward within one call.
  function automatic logic [15:0] bcd_inc(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (d[3:0] != UNIT_MAX) begin
      r[3:0] = d[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (d[7:4] != TENS_MAX) begin
        r[7:4] = d[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (d[11:8] != UNIT_MAX) begin
          r[11:8] = d[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (d[15:12] != TENS_MAX) r[15:12] = d[15:12] + 4'd1;
          else                      r[15:12] = 4'd0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Raw button to one-cycle press pulse: 2-flop synchronizer, counter debouncer
// and rising-edge detector.
module btn_pulse #(
  parameter int DEBOUNCE = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1, sync2;
  logic          level, level_d;
  logic [1:0]    fill;
  logic          armed;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      fill    <= 2'b00;
      armed   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      fill    <= {fill[0], 1'b1};
      level_d <= level;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      // Only a button seen released after the synchronizer has refilled may
      // produce a press, so one held through reset stays silent.
      if (fill[1] && !sync2 && !level) armed <= 1'b1;
    end
  end

  assign pulse = level & ~level_d & armed;

endmodule

// File: rtl/stopwatch_bcd.sv
// mm:ss BCD stopwatch: start/stop and clear buttons drive an IDLE/RUN/PAUSE
// FSM that gates a one-second prescaler feeding the BCD counter.
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int DEBOUNCE = 1000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [15:0] digits,
  output logic        running,
  output logic        wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          ss_p, clr_p, tick;

  btn_pulse #(.DEBOUNCE(DEBOUNCE)) u_ss  (.clk(clk), .rstn(rstn), .btn(btn_ss),  .pulse(ss_p));
  btn_pulse #(.DEBOUNCE(DEBOUNCE)) u_clr (.clk(clk), .rstn(rstn), .btn(btn_clr), .pulse(clr_p));

  assign tick = (state == RUN) && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      presc   <= '0;
      digits  <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_p) begin
        state   <= IDLE;
        presc   <= '0;
        digits  <= '0;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (ss_p) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            // Pausing freezes the prescaler so the partial second resumes.
            if (ss_p) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              presc  <= '0;
              digits <= bcd_inc(digits);
              wrap   <= (digits == DIGITS_MAX);
            end else begin
              presc <= presc + PW'(1);
            end
          end
          PAUSE: begin
            if (ss_p) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with TICK_DIV=4, DEBOUNCE=2.
module tb_stopwatch_bcd;

  logic        clk = 1'b0;
  logic        rstn;
  logic        btn_ss;
  logic        btn_clr;
  logic [15:0] digits;
  logic        running;
  logic        wrap;

  int n_assert = 0;
  int n_fail   = 0;

  stopwatch_bcd #(.TICK_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rstn(rstn), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .digits(digits), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A press is sampled by the FSM on the 5th rising edge after the drive.
  task automatic press_ss();
    btn_ss = 1'b1;
    step(5);
    btn_ss = 1'b0;
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    step(5);
    btn_clr = 1'b0;
  endtask

  // Every nibble must stay in its legal BCD range at all times.
  always @(negedge clk) begin
    if (rstn === 1'b1)
      check("nibble_range",
            {15'd0, (digits[3:0] <= 4'd9) && (digits[7:4] <= 4'd5) &&
                    (digits[11:8] <= 4'd9) && (digits[15:12] <= 4'd5)},
            16'd1);
  end

  initial begin
    rstn = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0;
    step(2);
    check("rst_digits",  digits,          16'h0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_wrap",    {15'd0, wrap},    16'd0);
    rstn = 1'b1;
    step(5);

    // Start and first second
    press_ss();
    check("start_running", {15'd0, running}, 16'd1);
    check("start_digits",  digits,          16'h0000);
    step(4);
    check("first_sec", digits, 16'h0001);

    // Pause with prescaler at 2, hold 20 cycles, resume
    step(2);
    press_ss();
    check("pause_running", {15'd0, running}, 16'd0);
    check("pause_digits",  digits,          16'h0002);
    step(20);
    check("pause_frozen",  digits,          16'h0002);
    press_ss();
    check("resume_running", {15'd0, running}, 16'd1);
    step(1);
    check("resume_plus1", digits, 16'h0002);
    step(1);
    check("resume_plus2", digits, 16'h0003);

    // ss and clr together at 00:37
    step(4 * 34);
    check("at_0037", digits, 16'h0037);
    btn_ss = 1'b1; btn_clr = 1'b1;
    step(5);
    check("clr_ss_digits",  digits,          16'h0000);
    check("clr_ss_running", {15'd0, running}, 16'd0);
    check("clr_ss_wrap",    {15'd0, wrap},    16'd0);
    btn_ss = 1'b0; btn_clr = 1'b0;
    step(10);
    check("clr_idle_hold", digits, 16'h0000);

    // Glitch ignored, long hold gives exactly one press
    btn_ss = 1'b1;
    step(1);
    btn_ss = 1'b0;
    step(10);
    check("glitch_running", {15'd0, running}, 16'd0);
    btn_ss = 1'b1;
    step(50);
    btn_ss = 1'b0;
    step(10);
    check("hold_running", {15'd0, running}, 16'd1);
    check("hold_digits",  digits,          16'h0013);

    // Long run through carries and the 59:59 wrap
    press_clr();
    check("clr_running", {15'd0, running}, 16'd0);
    check("clr_digits",  digits,          16'h0000);
    press_ss();
    step(4 * 599);
    check("at_0959", digits, 16'h0959);
    step(4);
    check("carry_1000", digits, 16'h1000);
    step(4 * 2999);
    check("at_5959", digits, 16'h5959);
    check("pre_wrap", {15'd0, wrap}, 16'd0);
    step(3);
    check("hold_5959", digits, 16'h5959);
    step(1);
    check("wrap_digits",  digits,          16'h0000);
    check("wrap_pulse",   {15'd0, wrap},    16'd1);
    check("wrap_running", {15'd0, running}, 16'd1);
    step(1);
    check("wrap_one_cycle", {15'd0, wrap}, 16'd0);
    step(3);
    check("after_wrap", digits, 16'h0001);

    // Reset mid-count at 01:09 with btn_ss held through release
    step(4 * 68);
    check("at_0109", digits, 16'h0109);
    btn_ss = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check("async_rst_digits",  digits,          16'h0000);
    check("async_rst_running", {15'd0, running}, 16'd0);
    step(2);
    rstn = 1'b1;
    step(20);
    check("held_rst_running", {15'd0, running}, 16'd0);
    check("held_rst_digits",  digits,          16'h0000);
    btn_ss = 1'b0;
    step(10);
    check("release_running", {15'd0, running}, 16'd0);
    press_ss();
    check("post_rst_running", {15'd0, running}, 16'd1);
    step(4);
    check("post_rst_digits", digits, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
